// File: rtl/ohc9_add_arbiter.sv
// Round-robin arbiter sharing one one-hot mod-9 adder among NUM_REQ requesters.
// Optional operand one-hot checking is enabled by defining OHC9_ERR_CHECK_EN.
module ohc9_add_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [9*NUM_REQ-1:0]   req_a,
    input  logic [9*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8:0]             out_sum_ohc,
    output logic [3:0]             out_sum_bin,
    output logic [ID_W-1:0]        out_id,
    output logic                   out_err
);

    localparam int unsigned OHC_W = 9;
    localparam int unsigned BIN_W = 4;

    typedef enum logic {ST_EMPTY, ST_FULL} state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [OHC_W-1:0]   sum_ohc_q, sum_ohc_d;
    logic [BIN_W-1:0]   sum_bin_q, sum_bin_d;
    logic [ID_W-1:0]    id_q, id_d;

    logic [OHC_W-1:0]   a_arr [NUM_REQ];
    logic [OHC_W-1:0]   b_arr [NUM_REQ];
    logic [2*NUM_REQ-1:0] rv_rot;
    logic               grant_vld;
    logic [ID_W-1:0]    grant_idx;
    int unsigned        grant_sum;
    logic               slot_free;
    logic               accept;
    logic [OHC_W-1:0]   a_sel, b_sel;
    logic [BIN_W-1:0]   b_idx;
    logic [2*OHC_W-1:0] a_rot;
    logic [OHC_W-1:0]   res_ohc;
    logic [BIN_W-1:0]   res_bin;

    // Binary of a one-hot residue; non-one-hot patterns encode as 0.
    function automatic logic [BIN_W-1:0] ohc_to_bin(input logic [OHC_W-1:0] v);
        logic [BIN_W-1:0] r;
        r = '0;
        if ($onehot(v)) begin
            for (int k = 0; k < int'(OHC_W); k++) begin
                if (v[k]) r = BIN_W'(k);
            end
        end
        return r;
    endfunction

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign a_arr[gi] = req_a[OHC_W*gi +: OHC_W];
        assign b_arr[gi] = req_b[OHC_W*gi +: OHC_W];
    end

    // Circular first-valid scan starting at rr_ptr_q.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_sum = 0;
        rv_rot    = {req_valid, req_valid} >> rr_ptr_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!grant_vld && rv_rot[i]) begin
                grant_vld = 1'b1;
                grant_sum = 32'(rr_ptr_q) + i;
                if (grant_sum >= NUM_REQ) grant_sum = grant_sum - NUM_REQ;
                grant_idx = ID_W'(grant_sum);
            end
        end
    end

    assign slot_free = (state_q == ST_EMPTY) || out_ready;
    assign accept    = grant_vld && slot_free && !rst;
    assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

    // Mod-9 add: rotate A left by the residue index of B.
    always_comb begin
        a_sel = a_arr[grant_idx];
        b_sel = b_arr[grant_idx];
        b_idx = '0;
        for (int k = 0; k < int'(OHC_W); k++) begin
            if (b_sel[k]) b_idx = BIN_W'(k);
        end
        a_rot   = {a_sel, a_sel} << b_idx;
        res_ohc = a_rot[2*OHC_W-1:OHC_W];
        res_bin = ohc_to_bin(res_ohc);
`ifdef OHC9_ERR_CHECK_EN
        if (!$onehot(a_sel) || !$onehot(b_sel)) begin
            res_ohc = OHC_W'(1);
            res_bin = '0;
        end
`endif
    end

`ifdef OHC9_ERR_CHECK_EN
    logic err_q, err_d;
    logic res_err;
    assign res_err = !$onehot(a_sel) || !$onehot(b_sel);
    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

    // Output-register state machine and next-state datapath.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        sum_ohc_d = sum_ohc_q;
        sum_bin_d = sum_bin_q;
        id_d      = id_q;
`ifdef OHC9_ERR_CHECK_EN
        err_d     = err_q;
`endif
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (accept) state_d = ST_FULL;
                      else if (out_ready) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
        if (accept) begin
            rr_ptr_d  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            sum_ohc_d = res_ohc;
            sum_bin_d = res_bin;
            id_d      = grant_idx;
`ifdef OHC9_ERR_CHECK_EN
            err_d     = res_err;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            rr_ptr_q  <= '0;
            sum_ohc_q <= OHC_W'(1);
            sum_bin_q <= '0;
            id_q      <= '0;
`ifdef OHC9_ERR_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            sum_ohc_q <= sum_ohc_d;
            sum_bin_q <= sum_bin_d;
            id_q      <= id_d;
`ifdef OHC9_ERR_CHECK_EN
            err_q     <= err_d;
`endif
        end
    end

    assign out_valid   = (state_q == ST_FULL);
    assign out_sum_ohc = sum_ohc_q;
    assign out_sum_bin = sum_bin_q;
    assign out_id      = id_q;

endmodule

// File: doc/ohc9_add_arbiter.md
# ohc9_add_arbiter

Round-robin arbiter and sequencer that shares one one-hot-coded (OHC) modulo-9 adder among NUM_REQ requesters in the RNS modulo adder datapath. Each requester presents two mod-9 residues in 9-bit one-hot form. The block grants one requester per cycle, computes the sum mod 9 with a rotate, and registers it. The result is returned both in one-hot form and as a 4-bit binary value using the codebase's OHC-9-to-binary encoding, tagged with the requester ID, over a valid/ready output handshake.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of out_id; must equal ceil(log2(NUM_REQ)), minimum 1

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- req_valid  in  NUM_REQ  requester i has an operand pair pending
- req_a  in  9*NUM_REQ  operand A of requester i, one-hot, bits [9i+8:9i]; bit k set means residue k
- req_b  in  9*NUM_REQ  operand B of requester i, one-hot, same packing
- req_ready  out  NUM_REQ  grant; requester i is accepted when req_valid[i] and req_ready[i] are both high
- out_valid  out  1  result register holds a valid result
- out_ready  in  1  downstream accepts the result
- out_sum_ohc  out  9  (a+b) mod 9, one-hot
- out_sum_bin  out  4  binary of out_sum_ohc; bit k maps to value k, and bit 0 or any non-one-hot pattern maps to 0
- out_id  out  ID_W  index of the requester that produced the result
- out_err  out  1  an operand was not one-hot (only when OHC9_ERR_CHECK_EN is defined)

## Operation
- Slot free condition: slot_free = !out_valid || out_ready.
- Grant rule:
  - When slot_free is high, exactly one req_ready bit is raised.
  - It goes to the first requester with req_valid high, scanning circularly from rr_ptr.
  - When slot_free is low, req_ready is all 0.
- req_ready is combinational from req_valid, rr_ptr and slot_free. It never depends on req_a or req_b.
- Pointer update: on acceptance of requester g, rr_ptr <= (g+1) mod NUM_REQ. With no acceptance, rr_ptr holds.
- Arithmetic:
  - sum_ohc = req_a of the granted requester rotated left by idx(req_b), where idx = position of the set bit in B.
  - Bit k of A moves to bit (k+idx) mod 9, so the operation wraps at 9.
- Output update:
  - On acceptance, out_sum_ohc, out_sum_bin, out_id and out_err load from the granted requester and out_valid <= 1.
  - With no acceptance and out_ready high, out_valid <= 0.
  - Otherwise all output registers hold.
- Output register states:
  - EMPTY (out_valid=0) -> FULL on acceptance.
  - FULL -> FULL on drain and accept in the same cycle.
  - FULL -> EMPTY on drain with no acceptance.
  - FULL holds while out_ready is low.
- Output stability: while out_valid=1 and out_ready=0, all out_* signals are stable.
- Single requester: one active requester is served every cycle while slot_free is high.

## Timing
- Reset values:
  - out_valid=0, out_sum_ohc=9'b000000001, out_sum_bin=0, out_id=0, out_err=0, rr_ptr=0.
  - req_ready=0 during any cycle in which rst is high.
- Latency: a request accepted at edge T appears on out_valid/out_sum_* after edge T.
- Throughput: 1 result per cycle while out_ready is held high.
- Simultaneous drain and accept: the new result replaces the old one at the same edge, with no bubble.
- Reset mid-operation: a pending result is dropped. Requesters that are not granted must hold their operands.
- Backpressure: with out_ready=0 and out_valid=1, no grant is issued. Requests wait, and rr_ptr is unchanged.

## Configuration
- OHC9_ERR_CHECK_EN defined:
  - On acceptance, each of the granted A and B is checked for having exactly one bit set.
  - If either check fails, out_err <= 1, out_sum_ohc <= 9'b000000001 and out_sum_bin <= 0.
  - out_err is cleared by the next accepted valid pair.
- OHC9_ERR_CHECK_EN not defined:
  - out_err is tied to 0 and no checker logic exists.
  - The result for non-one-hot operands is unspecified.

## Test plan
- Reset: assert rst for 2 cycles with all req_valid high -> req_ready=0, out_valid=0, out_sum_ohc=9'h001, out_sum_bin=0 after release edge.
- Wrap-around arithmetic: req 0 presents A=residue 7, B=residue 5, out_ready=1 -> next cycle out_valid=1, out_sum_ohc=9'b000001000, out_sum_bin=3, out_id=0. Also sweep all 81 pairs and check (a+b) mod 9.
- Round-robin fairness: all 4 req_valid held high, out_ready=1 -> out_id sequence 0,1,2,3,0 on consecutive cycles; each req_ready is a single cycle wide.
- Backpressure: out_ready=0 with result FULL for 5 cycles -> req_ready=0 and outputs stable. Raise out_ready -> drain and new accept on the same edge, with no bubble.
- Sparse requests: only req 2 valid, then req 1 -> grant 2, then grant 1. Since rr_ptr=3 after the first grant, req 1 is found by wrap-around scan.
- Error check (macro defined): req 0 A=9'b000100100 -> out_err=1, out_sum_bin=0. The next valid pair clears out_err. Without the macro, out_err stays 0.
